hazard_ctrl: RTL

- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Keeps its own shadow copy of the destination register, write-enable and write-back select for the instructions in EX and MEM.
- Generates the per-operand hazard flags that drive the ID-stage forwarding mux, plus load-use and HI/LO-busy stalls.
- Sequences the multi-cycle multiply/divide unit with an internal busy counter.

---
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: forwarding flags, load-use and HI/LO-busy stalls.
// Optional perf counters are built in when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 2,
   parameter int unsigned DIV_CYCLES = 33,
   parameter int unsigned CNT_W      = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_rs_used,
   input  logic       id_rt_used,
   input  logic       id_rf_we,
   input  logic [4:0] id_rf_waddr,
   input  logic [2:0] id_rf_wsel,
   input  logic       id_muldiv,
   input  logic       id_is_div,
   input  logic       id_hilo_acc,
   input  logic       mem_stall,
   output logic       id_ex_rs_hazard_reg,
   output logic       id_ex_rt_hazard_reg,
   output logic       id_ex_hazard_mem,
   output logic       id_mem_rs_hazard_mem,
   output logic       id_mem_rt_hazard_mem,
   output logic       id_mem_rs_hazard_reg,
   output logic       id_mem_rt_hazard_reg,
   output logic       stall_if,
   output logic       stall_id,
   output logic       bubble_ex,
   output logic       muldiv_start,
   output logic       hilo_busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_load_stalls,
   output logic [31:0] perf_hilo_stalls
`endif
);

   localparam logic [2:0] WSEL_RAM = 3'b011;
   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] BUSY     = 1'b1;

   logic             ex_we_q, ex_we_d, mem_we_q, mem_we_d;
   logic [4:0]       ex_waddr_q, ex_waddr_d, mem_waddr_q, mem_waddr_d;
   logic [2:0]       ex_wsel_q, ex_wsel_d, mem_wsel_q, mem_wsel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [0:0]       state;

   logic ex_rs, ex_rt, mem_rs, mem_rt;
   logic ex_is_load, mem_is_load;
   logic load_use, busy, muldiv_stall, stall_raw, issue;

   // Match terms: EX wins over MEM, so MEM flags are masked by the EX match.
   always_comb begin
      ex_rs       = id_valid & id_rs_used & ex_we_q  & (ex_waddr_q  == id_rs);
      ex_rt       = id_valid & id_rt_used & ex_we_q  & (ex_waddr_q  == id_rt);
      mem_rs      = id_valid & id_rs_used & mem_we_q & (mem_waddr_q == id_rs);
      mem_rt      = id_valid & id_rt_used & mem_we_q & (mem_waddr_q == id_rt);
      ex_is_load  = (ex_wsel_q  == WSEL_RAM);
      mem_is_load = (mem_wsel_q == WSEL_RAM);
      load_use     = (ex_rs | ex_rt) & ex_is_load;
      busy         = (cnt_q != '0);
      muldiv_stall = busy & id_valid & (id_muldiv | id_hilo_acc);
      stall_raw    = mem_stall | load_use | muldiv_stall;
      issue        = id_valid & id_muldiv & ~stall_raw & ~mem_stall;
   end

   // Outputs are forced low while reset is asserted.
   always_comb begin
      id_ex_rs_hazard_reg  = ~reset & ex_rs & ~ex_is_load;
      id_ex_rt_hazard_reg  = ~reset & ex_rt & ~ex_is_load;
      id_ex_hazard_mem     = ~reset & load_use;
      id_mem_rs_hazard_mem = ~reset & mem_rs & ~ex_rs & mem_is_load;
      id_mem_rt_hazard_mem = ~reset & mem_rt & ~ex_rt & mem_is_load;
      id_mem_rs_hazard_reg = ~reset & mem_rs & ~ex_rs & ~mem_is_load;
      id_mem_rt_hazard_reg = ~reset & mem_rt & ~ex_rt & ~mem_is_load;
      stall_id             = ~reset & stall_raw;
      stall_if             = ~reset & stall_raw;
      bubble_ex            = ~reset & stall_raw & ~mem_stall;
      muldiv_start         = ~reset & issue;
      hilo_busy            = ~reset & busy;
   end

   // NOTE: every signal gets a hold default first so no path through this block infers a latch.
   always_comb begin
      ex_we_d     = ex_we_q;
      ex_waddr_d  = ex_waddr_q;
      ex_wsel_d   = ex_wsel_q;
      mem_we_d    = mem_we_q;
      mem_waddr_d = mem_waddr_q;
      mem_wsel_d  = mem_wsel_q;
      if (!mem_stall) begin
         mem_we_d    = ex_we_q;
         mem_waddr_d = ex_waddr_q;
         mem_wsel_d  = ex_wsel_q;
         if (stall_raw) begin
            ex_we_d    = 1'b0;
            ex_waddr_d = 5'd0;
            ex_wsel_d  = 3'd0;
         end else begin
            ex_we_d    = id_valid & id_rf_we & (id_rf_waddr != 5'd0);
            ex_waddr_d = id_rf_waddr;
            ex_wsel_d  = id_rf_wsel;
         end
      end
   end

   // Busy counter keeps running through mem_stall; a new op only issues from IDLE.
   always_comb begin
      state = busy ? BUSY : IDLE;
      cnt_d = cnt_q;
      case (state)
         IDLE:    if (issue) cnt_d = id_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
         BUSY:    cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_we_q     <= 1'b0;
         ex_waddr_q  <= 5'd0;
         ex_wsel_q   <= 3'd0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= 5'd0;
         mem_wsel_q  <= 3'd0;
         cnt_q       <= '0;
      end else begin
         ex_we_q     <= ex_we_d;
         ex_waddr_q  <= ex_waddr_d;
         ex_wsel_q   <= ex_wsel_d;
         mem_we_q    <= mem_we_d;
         mem_waddr_q <= mem_waddr_d;
         mem_wsel_q  <= mem_wsel_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_load_q, perf_load_d, perf_hilo_q, perf_hilo_d;

   always_comb begin
      perf_load_d = perf_load_q;
      perf_hilo_d = perf_hilo_q;
      if (load_use && !mem_stall && perf_load_q != 32'hFFFF_FFFF)
         perf_load_d = perf_load_q + 32'd1;
      if (muldiv_stall && !mem_stall && perf_hilo_q != 32'hFFFF_FFFF)
         perf_hilo_d = perf_hilo_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_load_q <= 32'd0;
         perf_hilo_q <= 32'd0;
      end else begin
         perf_load_q <= perf_load_d;
         perf_hilo_q <= perf_hilo_d;
      end
   end

   assign perf_load_stalls = perf_load_q;
   assign perf_hilo_stalls = perf_hilo_q;
`endif

endmodule
